// File: rtl/branch_control.sv
// Branch resolution: funct3 + ALU flags -> taken decision, plus stats.
// Ports: clk, rst, B_control, Z/O/C/Nflag, Branch -> BranchTaken(_q),
//        branch_illegal, branch_count, taken_count.
module branch_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  B_control,
    input  logic        Zflag,
    input  logic        Oflag,
    input  logic        Cflag,
    input  logic        Nflag,
    input  logic        Branch,
    output logic        BranchTaken,
    output logic        BranchTaken_q,
    output logic        branch_illegal,
    output logic [31:0] branch_count,
    output logic [31:0] taken_count
);

    logic        cond;
    logic        reserved;
    logic [31:0] branch_count_d;
    logic [31:0] taken_count_d;

    always_comb begin
        cond = 1'b0;
        case (B_control)
            3'b000:  cond = Zflag;
            3'b001:  cond = ~Zflag;
            3'b100:  cond = Nflag ^ Oflag;
            3'b101:  cond = ~(Nflag ^ Oflag);
            3'b110:  cond = ~Cflag;
            3'b111:  cond = Cflag;
            default: cond = 1'b0;
        endcase
    end

    assign reserved       = (B_control == 3'b010) | (B_control == 3'b011);
    assign BranchTaken    = Branch & cond;
    assign branch_illegal = Branch & reserved;

    // Next-count nets kept separate from the registers.
    assign branch_count_d = branch_count + {31'd0, Branch};
    assign taken_count_d  = taken_count + {31'd0, BranchTaken};

    always_ff @(posedge clk) begin
        if (rst) begin
            BranchTaken_q <= 1'b0;
            branch_count  <= 32'd0;
            taken_count   <= 32'd0;
        end else begin
            BranchTaken_q <= BranchTaken;
            branch_count  <= branch_count_d;
            taken_count   <= taken_count_d;
        end
    end

endmodule

// File: tb/tb_branch_control.sv
// Directed testbench for branch_control.
// Hand-computed expectations checked through one task.
module tb_branch_control;

    logic        clk;
    logic        rst;
    logic [2:0]  B_control;
    logic        Zflag;
    logic        Oflag;
    logic        Cflag;
    logic        Nflag;
    logic        Branch;
    logic        BranchTaken;
    logic        BranchTaken_q;
    logic        branch_illegal;
    logic [31:0] branch_count;
    logic [31:0] taken_count;

    int checks;
    int errors;

    branch_control dut (
        .clk            (clk),
        .rst            (rst),
        .B_control      (B_control),
        .Zflag          (Zflag),
        .Oflag          (Oflag),
        .Cflag          (Cflag),
        .Nflag          (Nflag),
        .Branch         (Branch),
        .BranchTaken    (BranchTaken),
        .BranchTaken_q  (BranchTaken_q),
        .branch_illegal (branch_illegal),
        .branch_count   (branch_count),
        .taken_count    (taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] bc, input logic z,
                         input logic o, input logic c,
                         input logic n, input logic br);
        B_control = bc;
        Zflag     = z;
        Oflag     = o;
        Cflag     = c;
        Nflag     = n;
        Branch    = br;
    endtask

    // Combinational vectors: {bc, z, o, c, n, br, expected taken}
    localparam int NV = 17;
    logic [8:0] vec [NV] = '{
        {3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
        {3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
        {3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
        {3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
        {3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
        {3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
        {3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1},
        {3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0},
        {3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
        {3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
        {3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
        {3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0},
        {3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1},
        {3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
        {3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
        {3'b101, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1},
        {3'b100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1}
    };

    // Counter sequence: {bc, z, c, expected taken}
    logic [5:0] seq [5] = '{
        {3'b000, 1'b1, 1'b0, 1'b1},
        {3'b000, 1'b0, 1'b0, 1'b0},
        {3'b001, 1'b0, 1'b0, 1'b1},
        {3'b110, 1'b0, 1'b0, 1'b1},
        {3'b111, 1'b0, 1'b0, 1'b0}
    };

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        drive(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        @(posedge clk);
        #1;
        check("rst_q", {31'd0, BranchTaken_q}, 32'd0);
        check("rst_bcnt", branch_count, 32'd0);
        check("rst_tcnt", taken_count, 32'd0);

        // Decision is combinational, so it works with rst held high.
        for (int i = 0; i < NV; i++) begin
            logic [8:0] v;
            v = vec[i];
            @(negedge clk);
            drive(v[8:6], v[5], v[4], v[3], v[2], v[1]);
            #1;
            check($sformatf("comb_%0d", i), {31'd0, BranchTaken},
                  {31'd0, v[0]});
            check($sformatf("ill_%0d", i), {31'd0, branch_illegal}, 32'd0);
        end

        for (int k = 0; k < 2; k++) begin
            for (int f = 0; f < 16; f++) begin
                logic [3:0] fl;
                fl = 4'(f);
                drive(k == 0 ? 3'b010 : 3'b011, fl[3], fl[2], fl[1],
                      fl[0], 1'b1);
                #1;
                check($sformatf("rsv_tk_%0d_%0d", k, f),
                      {31'd0, BranchTaken}, 32'd0);
                check($sformatf("rsv_il_%0d_%0d", k, f),
                      {31'd0, branch_illegal}, 32'd1);
            end
            Branch = 1'b0;
            #1;
            check($sformatf("rsv_nobr_%0d", k),
                  {31'd0, branch_illegal}, 32'd0);
        end

        // Five branch cycles, three taken.
        for (int i = 0; i < 5; i++) begin
            logic [5:0] s;
            s = seq[i];
            @(negedge clk);
            rst = 1'b0;
            drive(s[5:3], s[2], 1'b0, s[1], 1'b0, 1'b1);
            #1;
            check($sformatf("seq_tk_%0d", i), {31'd0, BranchTaken},
                  {31'd0, s[0]});
            @(posedge clk);
            #1;
            check($sformatf("seq_q_%0d", i), {31'd0, BranchTaken_q},
                  {31'd0, s[0]});
        end
        check("cnt_branch", branch_count, 32'd5);
        check("cnt_taken", taken_count, 32'd3);

        @(negedge clk);
        drive(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("idle_bcnt", branch_count, 32'd5);
        check("idle_tcnt", taken_count, 32'd3);
        check("idle_q", {31'd0, BranchTaken_q}, 32'd0);

        // Reset wins over a taken branch.
        @(negedge clk);
        rst = 1'b1;
        drive(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check("rst_comb", {31'd0, BranchTaken}, 32'd1);
        @(posedge clk);
        #1;
        check("rst2_q", {31'd0, BranchTaken_q}, 32'd0);
        check("rst2_bcnt", branch_count, 32'd0);
        check("rst2_tcnt", taken_count, 32'd0);

        // Preload branch_count to all ones via its next-value net.
        @(negedge clk);
        rst = 1'b0;
        Branch = 1'b0;
        force dut.branch_count_d = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.branch_count_d;
        check("pre_wrap", branch_count, 32'hFFFF_FFFF);

        @(negedge clk);
        drive(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("wrap_bcnt", branch_count, 32'd0);
        check("wrap_tcnt", taken_count, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_control.md
# branch_control

Branch-resolution unit of the RV32I core. It combines the branch `funct3` code with the ALU comparison flags, produced by subtracting rs2 from rs1, to decide whether a conditional branch is taken. The decision is combinational so the PC-select mux can use it in the same cycle. The block also keeps a registered copy of the decision and branch statistics counters for debug and performance monitoring.

## Interface
- No parameters. All widths are fixed.
- `clk` input 1: single clock; all registers update on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `B_control` input 3: branch `funct3` (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU).
- `Zflag` input 1: ALU zero (rs1 − rs2 == 0).
- `Oflag` input 1: ALU signed overflow of rs1 − rs2.
- `Cflag` input 1: ALU carry-out of rs1 + ~rs2 + 1 (1 = no borrow, meaning rs1 ≥ rs2 unsigned).
- `Nflag` input 1: ALU result bit 31.
- `Branch` input 1: the current instruction is a conditional branch (from the main control unit).
- `BranchTaken` output 1: combinational branch decision.
- `BranchTaken_q` output 1: `BranchTaken` registered on `clk`.
- `branch_illegal` output 1: combinational; `Branch`=1 with a reserved `B_control` (010 or 011).
- `branch_count` output 32: number of cycles in which `Branch`=1.
- `taken_count` output 32: number of cycles in which `BranchTaken`=1.

## Operation
- The condition `cond` is selected by `B_control`:
  - 000 BEQ: `Zflag`
  - 001 BNE: `~Zflag`
  - 100 BLT: `Nflag ^ Oflag`
  - 101 BGE: `~(Nflag ^ Oflag)`
  - 110 BLTU: `~Cflag`
  - 111 BGEU: `Cflag`
  - 010 and 011: 0, meaning never taken
- `BranchTaken = Branch & cond`. When `Branch`=0, the output is 0 regardless of `B_control` or the flags.
- `branch_illegal = Branch & (B_control == 010 | B_control == 011)`.
- `BranchTaken` and `branch_illegal` are purely combinational:
  - They do not depend on `clk`.
  - They are not forced by `rst`.
  - Their inputs must contain no latches and no X-propagating default cases.
- Counters:
  - `branch_count` increments by 1 in each cycle where `Branch`=1.
  - `taken_count` increments by 1 in each cycle where `BranchTaken`=1.
  - Both are unsigned, 32 bits, and wrap from 0xFFFFFFFF to 0.

## Timing
- `BranchTaken` and `branch_illegal` have zero-cycle latency: they are valid in the same cycle their inputs settle.
- `BranchTaken_q` equals the `BranchTaken` value sampled at the previous rising edge (1-cycle latency).
- On a rising edge with `rst`=1:
  - `BranchTaken_q` becomes 0.
  - `branch_count` becomes 0.
  - `taken_count` becomes 0.
  - Reset has priority over any increment in that cycle.
- In the first edge after `rst` deasserts, normal counting resumes using that cycle's inputs.
- Reset asserted in the middle of a branch sequence discards the accumulated counts. The combinational decision is unaffected.
- There is no handshake and no state machine. Every cycle is independent apart from the counters.

## Test plan
- **BEQ and gating:** `B_control`=000, Z=1, `Branch`=1 gives `BranchTaken`=1. Dropping `Branch` to 0 gives 0. Raising `Branch` to 1 again gives 1.
- **BNE, BLT, BGE:**
  - 001 with Z=0 gives 1, and with Z=1 gives 0.
  - 100 with N=1, O=0 gives 1, and with N=1, O=1 gives 0.
  - 101 with N=0, O=0 gives 1, and with N=0, O=1 gives 0.
- **Unsigned compares:** with `Branch`=1:
  - 110 with C=0 gives 1, and with C=1 gives 0.
  - 111 with C=1 gives 1, and with C=0 gives 0.
- **Reserved codes:** `B_control`=010 and 011 with `Branch`=1, swept over all 16 flag combinations, give `BranchTaken`=0 and `branch_illegal`=1. With `Branch`=0, `branch_illegal`=0.
- **Registered output and counters:**
  - Setup: after reset, run 5 branch cycles of which 3 are taken.
  - After the 5th edge: `branch_count`=5 and `taken_count`=3.
  - `BranchTaken_q` tracks `BranchTaken` delayed by one cycle.
- **Reset and wrap:**
  - Drive `rst`=1 in a cycle with `Branch`=1 and `BranchTaken`=1. After that edge, all registers are 0.
  - Force `branch_count` to 0xFFFFFFFF; one more branch cycle gives `branch_count`=0.
